// File: rtl/ecc_lut_arbiter_pkg.sv
// rtl/ecc_lut_arbiter_pkg.sv - shared types, defaults and LUT load mask for the ECC LUT arbiter
package ecc_lut_arbiter_pkg;

  localparam int DEF_DATA_W = 8;

  typedef enum logic [0:0] {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  typedef logic req_id_t;

  typedef struct packed {
    logic    vld;
    req_id_t id;
  } tag_t;

  // Bit a set iff table entry a is loaded; entries 0,1,2,5 are holes.
  localparam logic [255:0] LUT_MAP_MASK = {{248{1'b1}}, 8'hD8};

  function automatic logic lut_loaded(input logic [7:0] addr);
    return LUT_MAP_MASK[addr];
  endfunction

endpackage

// File: rtl/ecc_lut_arbiter_if.sv
// rtl/ecc_lut_arbiter_if.sv - requester, response and shared-LUT signal bundle (LUT_HOLE_FLAG_EN adds miss flags)
interface ecc_lut_arbiter_if #(
  parameter int DATA_W = 8
) ();

  logic              req0_valid;
  logic              req1_valid;
  logic [DATA_W-1:0] req0_data;
  logic [DATA_W-1:0] req1_data;
  logic              req0_ready;
  logic              req1_ready;
  logic              rsp0_valid;
  logic              rsp1_valid;
  logic [DATA_W-1:0] rsp0_data;
  logic [DATA_W-1:0] rsp1_data;
  logic              lut_reset;
  logic [DATA_W-1:0] lut_addr;
  logic [DATA_W-1:0] lut_data;
  logic              busy;
`ifdef LUT_HOLE_FLAG_EN
  logic              rsp0_miss;
  logic              rsp1_miss;

  modport slave (
    input  req0_valid, req1_valid, req0_data, req1_data, lut_data,
    output req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp0_data, rsp1_data,
    output lut_reset, lut_addr, busy, rsp0_miss, rsp1_miss
  );

  modport master (
    output req0_valid, req1_valid, req0_data, req1_data, lut_data,
    input  req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp0_data, rsp1_data,
    input  lut_reset, lut_addr, busy, rsp0_miss, rsp1_miss
  );
`else
  modport slave (
    input  req0_valid, req1_valid, req0_data, req1_data, lut_data,
    output req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp0_data, rsp1_data,
    output lut_reset, lut_addr, busy
  );

  modport master (
    output req0_valid, req1_valid, req0_data, req1_data, lut_data,
    input  req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp0_data, rsp1_data,
    input  lut_reset, lut_addr, busy
  );
`endif

endinterface

// File: rtl/ecc_rr_arb2.sv
// rtl/ecc_rr_arb2.sv - two-requester round-robin grant with internal priority pointer
module ecc_rr_arb2
  import ecc_lut_arbiter_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  input  logic [1:0] valid,
  output logic [1:0] gnt
);

  req_id_t ptr_q, ptr_d;

  always_comb begin
    gnt   = 2'b00;
    ptr_d = ptr_q;
    if (en) begin
      if (valid == 2'b11) begin
        gnt = (ptr_q == 1'b1) ? 2'b10 : 2'b01;
      end else begin
        gnt = valid;
      end
    end
    // Favour whoever was just passed over; hold when nothing transfers.
    if (gnt[0]) begin
      ptr_d = 1'b1;
    end else if (gnt[1]) begin
      ptr_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      ptr_q <= 1'b0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/ecc_lut_arbiter.sv
// rtl/ecc_lut_arbiter.sv - shares one registered LUT between two requesters; LUT_HOLE_FLAG_EN adds per-response miss flags
module ecc_lut_arbiter
  import ecc_lut_arbiter_pkg::*;
#(
  parameter int DATA_W      = DEF_DATA_W,
  parameter int INIT_CYCLES = 2
) (
  input  logic                clk,
  input  logic                reset,
  ecc_lut_arbiter_if.slave    bus
);

  state_e            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  tag_t              tag_q, tag_d;
  logic              rsp0_valid_q, rsp0_valid_d;
  logic              rsp1_valid_q, rsp1_valid_d;
  logic [DATA_W-1:0] rsp0_data_q, rsp0_data_d;
  logic [DATA_W-1:0] rsp1_data_q, rsp1_data_d;
  logic              run;
  logic [1:0]        gnt;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (state_q == ST_INIT) begin
      if (cnt_q == 4'(INIT_CYCLES - 1)) begin
        state_d = ST_RUN;
      end else begin
        cnt_d = cnt_q + 4'd1;
      end
    end
  end

  // Outputs are qualified by reset directly so the reset values appear
  // in the very first cycle reset is low, before the flops have cleared.
  assign run = reset && (state_q == ST_RUN);

  ecc_rr_arb2 u_arb (
    .clk   (clk),
    .reset (reset),
    .en    (run),
    .valid ({bus.req1_valid, bus.req0_valid}),
    .gnt   (gnt)
  );

  always_comb begin
    tag_d.vld    = |gnt;
    tag_d.id     = gnt[1];
    rsp0_valid_d = tag_q.vld && (tag_q.id == 1'b0);
    rsp1_valid_d = tag_q.vld && (tag_q.id == 1'b1);
    rsp0_data_d  = rsp0_valid_d ? bus.lut_data : rsp0_data_q;
    rsp1_data_d  = rsp1_valid_d ? bus.lut_data : rsp1_data_q;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= ST_INIT;
      cnt_q        <= 4'd0;
      tag_q        <= '0;
      rsp0_valid_q <= 1'b0;
      rsp1_valid_q <= 1'b0;
      rsp0_data_q  <= '0;
      rsp1_data_q  <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      tag_q        <= tag_d;
      rsp0_valid_q <= rsp0_valid_d;
      rsp1_valid_q <= rsp1_valid_d;
      rsp0_data_q  <= rsp0_data_d;
      rsp1_data_q  <= rsp1_data_d;
    end
  end

  assign bus.req0_ready = gnt[0];
  assign bus.req1_ready = gnt[1];
  assign bus.lut_addr   = gnt[0] ? bus.req0_data : (gnt[1] ? bus.req1_data : '0);
  assign bus.lut_reset  = !run;
  assign bus.busy       = !run || tag_q.vld;
  assign bus.rsp0_valid = reset && rsp0_valid_q;
  assign bus.rsp1_valid = reset && rsp1_valid_q;
  assign bus.rsp0_data  = reset ? rsp0_data_q : '0;
  assign bus.rsp1_data  = reset ? rsp1_data_q : '0;

`ifdef LUT_HOLE_FLAG_EN
  logic [DATA_W-1:0] addr_q, addr_d;
  logic              miss0_q, miss0_d;
  logic              miss1_q, miss1_d;

  // The address rides one cycle behind the grant so the hole lookup lines up with lut_data.
  always_comb begin
    addr_d  = bus.lut_addr;
    miss0_d = rsp0_valid_d ? !lut_loaded(8'(addr_q)) : miss0_q;
    miss1_d = rsp1_valid_d ? !lut_loaded(8'(addr_q)) : miss1_q;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      addr_q  <= '0;
      miss0_q <= 1'b0;
      miss1_q <= 1'b0;
    end else begin
      addr_q  <= addr_d;
      miss0_q <= miss0_d;
      miss1_q <= miss1_d;
    end
  end

  assign bus.rsp0_miss = reset && miss0_q;
  assign bus.rsp1_miss = reset && miss1_q;
`endif

endmodule

// File: doc/ecc_lut_arbiter.md
ECC_LUT_ARBITER -- requirements
Module: ecc_lut_arbiter

Interface
REQ-001 SHALL have parameter DATA_W, default 8, width of lookup address and data.
REQ-002 SHALL have parameter INIT_CYCLES, default 2, cycles lut_reset is held high after reset release (range 1..15).
REQ-003 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-low reset.
REQ-005 SHALL have ports req0_valid/req1_valid  input  1  requester has a lookup address.
REQ-006 SHALL have ports req0_data/req1_data  input  DATA_W  lookup address (plaintext x).
REQ-007 SHALL have ports req0_ready/req1_ready  output  1  grant; the transfer occurs when valid and ready are both high.
REQ-008 SHALL have ports rsp0_valid/rsp1_valid  output  1  one-cycle response strobe per requester.
REQ-009 SHALL have ports rsp0_data/rsp1_data  output  DATA_W  looked-up (encrypted) value.
REQ-010 SHALL have port lut_reset  output  1  active-high table-load control to the shared LUT.
REQ-011 SHALL have port lut_addr  output  DATA_W  address to the shared LUT, 0 when no grant.
REQ-012 SHALL have port lut_data  input  DATA_W  registered LUT output, valid one cycle after lut_addr.
REQ-013 SHALL have port busy  output  1  high in INIT or while any lookup is in flight.

Function
REQ-014 SHALL implement FSM states INIT and RUN; INIT→RUN after INIT_CYCLES cycles; there SHALL be no other transitions except reset→INIT.
REQ-015 In INIT: lut_reset=1, both ready=0, lut_addr=0.
REQ-016 In RUN: lut_reset=0; at most one grant per cycle; ready is combinational from valid, state, and the priority pointer.
REQ-017 Round-robin: with a single valid requester, that requester is granted; with both valid, the requester not granted most recently is granted; the pointer updates only on an accepted transfer; the pointer after reset favours requester 0.
REQ-018 lut_addr SHALL equal the granted req_data in the accept cycle t.
REQ-019 An owner tag (valid bit + requester id) SHALL be registered at the end of cycle t; at the end of cycle t+1, lut_data SHALL be registered into the owner's rsp_data and the owner's rsp_valid SHALL be raised; the response is visible in cycle t+2 (latency 2, throughput 1/cycle).
REQ-020 rsp_valid SHALL be high for exactly one cycle per accepted request; the non-owner rsp_valid SHALL stay 0; rsp_data SHALL hold its value between responses.
REQ-021 Responses SHALL have no backpressure; requests and responses stay in order per requester.
REQ-022 Simultaneous accept and response in the same cycle SHALL both complete, with no bubble.

Reset
REQ-023 While reset=0: state=INIT, init counter=0, pointer=requester 0, owner tag cleared, rsp*_valid=0, rsp*_data=0, lut_reset=1, ready=0, busy=1.
REQ-024 Reset mid-operation SHALL drop in-flight lookups with no response emitted, then rerun the full INIT sequence.

Configuration
REQ-025 Macro LUT_HOLE_FLAG_EN: when defined, outputs rsp0_miss/rsp1_miss (1 bit each) SHALL be added, registered alongside rsp_data, and set to 1 when the looked-up address is not loaded in the table according to the package mask. When the macro is undefined, these ports and the mask logic SHALL be absent and all other behaviour SHALL be identical.

Structure
REQ-026 A shared package SHALL hold the FSM state enum, DATA_W default, requester-id type, and LUT_MAP_MASK (256-bit; bit a set iff table entry a is loaded, e.g. bits 3,4,6,7 set, bits 0,1,2,5 clear).
REQ-027 The round-robin grant logic SHALL be one sub-module, ecc_rr_arb2 (2 valids in, 2 grants out, pointer internal).
REQ-028 The LUT itself SHALL be instantiated outside this block.

Verification
REQ-029 Hold reset low 3 cycles, then release -> lut_reset high for exactly 2 cycles after release, ready low throughout, req0_ready=1 in the 3rd cycle with req0_valid=1.
REQ-030 req0 sends 0x03 alone, LUT model connected -> rsp0_valid in t+2 with rsp0_data=0x04; rsp1_valid stays 0.
REQ-031 Both valid continuously, req0=0x0A, req1=0x1A -> grants alternate 0,1,0,1; rsp0_data=0x0B, rsp1_data=0x1B on alternate cycles.
REQ-032 req0 back-to-back sends 0x03, 0x04, 0x06 -> rsp0_valid on 3 consecutive cycles with data 0x04, 0x05, 0x07.
REQ-033 Reset low in the cycle after accepting 0x0C -> no rsp strobe, busy=1, INIT repeats; after INIT a fresh 0x0C returns 0x0D.
REQ-034 With LUT_HOLE_FLAG_EN defined: req1 sends 0x05 -> rsp1_miss=1; 0x06 -> rsp1_miss=0 with data 0x07. Without the macro: the same stimulus gives identical rsp data, and the miss ports do not exist.
